// File: rtl/tl_ul_a_arbiter_if.sv
// Bundle of per-requester A/D channels and the shared downstream A/D port.
// The arbiter takes the slave modport. The environment that drives the
// requesters and the downstream port takes the master modport.
interface tl_ul_a_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned SRC_W  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Requester-side A channels, packed with requester 0 in the low slice.
  logic [N_REQ-1:0]        in_a_valid;
  logic [N_REQ-1:0]        in_a_ready;
  logic [3*N_REQ-1:0]      in_a_opcode;
  logic [3*N_REQ-1:0]      in_a_param;
  logic [4*N_REQ-1:0]      in_a_size;
  logic [SRC_W*N_REQ-1:0]  in_a_source;
  logic [ADDR_W*N_REQ-1:0] in_a_address;
  logic [4*N_REQ-1:0]      in_a_mask;
  logic [DATA_W*N_REQ-1:0] in_a_data;

  // Shared downstream A channel.
  logic                    out_a_valid;
  logic                    out_a_ready;
  logic [2:0]              out_a_opcode;
  logic [2:0]              out_a_param;
  logic [3:0]              out_a_size;
  logic [3:0]              out_a_mask;
  logic [ADDR_W-1:0]       out_a_address;
  logic [DATA_W-1:0]       out_a_data;
  logic [IDX_W+SRC_W-1:0]  out_a_source;

  // Shared downstream D channel (source only) and the per-requester D routing.
  logic                    out_d_valid;
  logic                    out_d_ready;
  logic [IDX_W+SRC_W-1:0]  out_d_source;
  logic [N_REQ-1:0]        in_d_valid;
  logic [N_REQ-1:0]        in_d_ready;
  logic [SRC_W-1:0]        in_d_source;

  modport master (
    output in_a_valid, in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address,
    output in_a_mask, in_a_data, out_a_ready, out_d_valid, out_d_source, in_d_ready,
    input  in_a_ready, out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_mask,
    input  out_a_address, out_a_data, out_a_source, out_d_ready, in_d_valid, in_d_source
  );

  modport slave (
    input  in_a_valid, in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address,
    input  in_a_mask, in_a_data, out_a_ready, out_d_valid, out_d_source, in_d_ready,
    output in_a_ready, out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_mask,
    output out_a_address, out_a_data, out_a_source, out_d_ready, in_d_valid, in_d_source
  );
endinterface

// File: rtl/tl_ul_a_arbiter.sv
// Round-robin TL-UL A-channel arbiter with burst locking, source-index
// prefixing on A and index-based routing of D responses back to requesters.
module tl_ul_a_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned SRC_W  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  tl_ul_a_arbiter_if.slave    bus,
  output logic                err_sticky
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SW    = IDX_W + SRC_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             hold_q;
  logic [IDX_W-1:0] hold_idx_q;
  logic [IDX_W-1:0] lock_q;
  logic [12:0]      beats_left_q;
  logic             err_q;

  logic [IDX_W-1:0] sel;
  logic             a_valid;
  logic [N_REQ-1:0] grant;
  logic [2:0]       sel_opcode;
  logic [2:0]       sel_param;
  logic [3:0]       sel_size;
  logic [3:0]       sel_mask;
  logic [SRC_W-1:0] sel_source;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_data;
  logic             a_fire;
  logic             is_burst;
  logic [12:0]      first_beats;
  logic [IDX_W-1:0] rr_next;

  logic [IDX_W-1:0] d_idx;
  logic             d_hit;
  logic             d_rdy;
  logic             d_drop;
  logic [N_REQ-1:0] d_valid_vec;

  // Pick the winner: locked requester in a burst, frozen index while stalled,
  // otherwise the first valid requester scanning upward from rr_ptr_q.
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = '0;
    if (state_q == StBurst) begin
      sel = lock_q;
    end else if (hold_q) begin
      sel = hold_idx_q;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!found && bus.in_a_valid[(32'(rr_ptr_q) + k) % N_REQ]) begin
          found = 1'b1;
          sel   = IDX_W'((32'(rr_ptr_q) + k) % N_REQ);
        end
      end
    end
  end

  // Mux the winner's payload; everything is zero when the winner is not valid.
  always_comb begin
    a_valid     = 1'b0;
    grant       = '0;
    sel_opcode  = '0;
    sel_param   = '0;
    sel_size    = '0;
    sel_mask    = '0;
    sel_source  = '0;
    sel_address = '0;
    sel_data    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel == IDX_W'(i) && bus.in_a_valid[i]) begin
        a_valid     = 1'b1;
        grant[i]    = 1'b1;
        sel_opcode  = bus.in_a_opcode[3*i +: 3];
        sel_param   = bus.in_a_param[3*i +: 3];
        sel_size    = bus.in_a_size[4*i +: 4];
        sel_mask    = bus.in_a_mask[4*i +: 4];
        sel_source  = bus.in_a_source[SRC_W*i +: SRC_W];
        sel_address = bus.in_a_address[ADDR_W*i +: ADDR_W];
        sel_data    = bus.in_a_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign a_fire      = a_valid & bus.out_a_ready;
  // PutFullData (0) and PutPartialData (1) wider than one 4-byte beat lock the bus.
  assign is_burst    = (sel_opcode == 3'd0 || sel_opcode == 3'd1) && (sel_size > 4'd2);
  assign first_beats = (13'd1 << (sel_size - 4'd2)) - 13'd1;
  assign rr_next     = (sel == LastIdx) ? '0 : sel + IDX_W'(1);

  assign bus.out_a_valid   = a_valid;
  assign bus.in_a_ready    = grant & {N_REQ{bus.out_a_ready}};
  assign bus.out_a_opcode  = sel_opcode;
  assign bus.out_a_param   = sel_param;
  assign bus.out_a_size    = sel_size;
  assign bus.out_a_mask    = sel_mask;
  assign bus.out_a_address = sel_address;
  assign bus.out_a_data    = sel_data;
  assign bus.out_a_source  = a_valid ? {sel, sel_source} : '0;

  // D routing is stateless: the top index bits select the requester.
  always_comb begin
    d_idx       = bus.out_d_source[SW-1 -: IDX_W];
    d_hit       = 1'b0;
    d_rdy       = 1'b0;
    d_valid_vec = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (d_idx == IDX_W'(i)) begin
        d_hit          = 1'b1;
        d_rdy          = bus.in_d_ready[i];
        d_valid_vec[i] = bus.out_d_valid;
      end
    end
    d_drop = bus.out_d_valid & ~d_hit;
  end

  assign bus.in_d_valid  = d_valid_vec;
  assign bus.in_d_source = bus.out_d_source[SRC_W-1:0];
  // Unroutable beats are swallowed so the downstream port never stalls on them.
  assign bus.out_d_ready = d_hit ? d_rdy : d_drop;
  assign err_sticky      = err_q;

  // Arbitration FSM: round-robin pointer, stall hold, burst lock and beat count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      hold_q       <= 1'b0;
      hold_idx_q   <= '0;
      lock_q       <= '0;
      beats_left_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (d_drop) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (a_fire) begin
            hold_q   <= 1'b0;
            rr_ptr_q <= rr_next;
            if (is_burst) begin
              beats_left_q <= first_beats;
              lock_q       <= sel;
              state_q      <= StBurst;
            end
          end else if (a_valid) begin
            hold_q     <= 1'b1;
            hold_idx_q <= sel;
          end
        end
        StBurst: begin
          if (a_fire) begin
            if (beats_left_q == 13'd1) begin
              beats_left_q <= '0;
              state_q      <= StIdle;
            end else begin
              beats_left_q <= beats_left_q - 13'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Directed bench for tl_ul_a_arbiter: a vector table for arbitration and D
// routing on a 2-requester instance, plus sequences for bursts, reset
// mid-burst and unroutable D beats on a 3-requester instance.
module tb_tl_ul_a_arbiter;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  logic clock;
  logic reset_n;
  logic err2;
  logic err3;

  tl_ul_a_arbiter_if #(.N_REQ(2), .SRC_W(2), .ADDR_W(32), .DATA_W(32)) bus2 ();
  tl_ul_a_arbiter_if #(.N_REQ(3), .SRC_W(2), .ADDR_W(32), .DATA_W(32)) bus3 ();

  tl_ul_a_arbiter #(.N_REQ(2), .SRC_W(2), .ADDR_W(32), .DATA_W(32)) dut2 (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus2),
    .err_sticky (err2)
  );

  tl_ul_a_arbiter #(.N_REQ(3), .SRC_W(2), .ADDR_W(32), .DATA_W(32)) dut3 (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus3),
    .err_sticky (err3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the 2-requester A side; sources and addresses stay fixed per requester.
  task automatic drive_a(input logic [1:0] v, input logic [2:0] op0, input logic [3:0] sz0,
                         input logic [2:0] op1, input logic [3:0] sz1, input logic rdy);
    bus2.in_a_valid  = v;
    bus2.in_a_opcode = {op1, op0};
    bus2.in_a_size   = {sz1, sz0};
    bus2.out_a_ready = rdy;
  endtask

  task automatic drive_d(input logic dv, input logic [2:0] dsrc, input logic [1:0] drdy);
    bus2.out_d_valid  = dv;
    bus2.out_d_source = dsrc;
    bus2.in_d_ready   = drdy;
  endtask

  // Inputs change 1 after the rising edge; checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic        rdy;
    logic        dv;
    logic [2:0]  dsrc;
    logic [1:0]  drdy;
    logic [1:0]  e_ar;
    logic        e_ov;
    logic [2:0]  e_osrc;
    logic [31:0] e_addr;
    logic [1:0]  e_dv;
    logic        e_dr;
    logic [1:0]  e_dsrc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus2.in_a_valid   = '0;
    bus2.in_a_opcode  = '0;
    bus2.in_a_param   = '0;
    bus2.in_a_size    = '0;
    bus2.in_a_source  = {2'b01, 2'b10};
    bus2.in_a_address = {A1, A0};
    bus2.in_a_mask    = 8'hff;
    bus2.in_a_data    = {32'hbbbb_0001, 32'haaaa_0000};
    bus2.out_a_ready  = 1'b0;
    bus2.out_d_valid  = 1'b0;
    bus2.out_d_source = '0;
    bus2.in_d_ready   = '0;
    bus3.in_a_valid   = '0;
    bus3.in_a_opcode  = '0;
    bus3.in_a_param   = '0;
    bus3.in_a_size    = '0;
    bus3.in_a_source  = '0;
    bus3.in_a_address = '0;
    bus3.in_a_mask    = '0;
    bus3.in_a_data    = '0;
    bus3.out_a_ready  = 1'b0;
    bus3.out_d_valid  = 1'b0;
    bus3.out_d_source = '0;
    bus3.in_d_ready   = '0;

    // Gets of 4 bytes throughout; src0=2'b10, src1=2'b01.
    //            v     rdy   dv    dsrc    drdy   ar     ov    osrc    addr   dv     dr    dsrc
    tbl[0]  = '{2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 3'b000, 32'h0, 2'b00, 1'b0, 2'b00};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 2'b01, 1'b1, 3'b010, A0,    2'b00, 1'b0, 2'b00};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 2'b10, 1'b1, 3'b101, A1,    2'b00, 1'b0, 2'b00};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 2'b01, 1'b1, 3'b010, A0,    2'b00, 1'b0, 2'b00};
    tbl[4]  = '{2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 2'b10, 1'b1, 3'b101, A1,    2'b00, 1'b0, 2'b00};
    tbl[5]  = '{2'b00, 1'b1, 1'b1, 3'b101, 2'b10, 2'b00, 1'b0, 3'b000, 32'h0, 2'b10, 1'b1, 2'b01};
    tbl[6]  = '{2'b00, 1'b1, 1'b1, 3'b010, 2'b10, 2'b00, 1'b0, 3'b000, 32'h0, 2'b01, 1'b0, 2'b10};
    tbl[7]  = '{2'b10, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 3'b101, A1,    2'b00, 1'b0, 2'b00};
    tbl[8]  = '{2'b11, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 3'b101, A1,    2'b00, 1'b0, 2'b00};
    tbl[9]  = '{2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 2'b10, 1'b1, 3'b101, A1,    2'b00, 1'b0, 2'b00};
    tbl[10] = '{2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 2'b01, 1'b1, 3'b010, A0,    2'b00, 1'b0, 2'b00};
    tbl[11] = '{2'b01, 1'b1, 1'b0, 3'b000, 2'b00, 2'b01, 1'b1, 3'b010, A0,    2'b00, 1'b0, 2'b00};
    tbl[12] = '{2'b10, 1'b1, 1'b1, 3'b100, 2'b11, 2'b10, 1'b1, 3'b101, A1,    2'b10, 1'b1, 2'b00};

    do_reset();
    @(negedge clock);
    chk("reset_err_sticky", 64'(err2), 64'd0);
    chk("reset_out_a_valid", 64'(bus2.out_a_valid), 64'd0);
    next_cycle();

    // Table: round-robin, D routing, stall hold, simultaneous A/D fire.
    for (int i = 0; i < 13; i++) begin
      drive_a(tbl[i].v, 3'd4, 4'd2, 3'd4, 4'd2, tbl[i].rdy);
      drive_d(tbl[i].dv, tbl[i].dsrc, tbl[i].drdy);
      @(negedge clock);
      chk($sformatf("v%0d_in_a_ready", i), 64'(bus2.in_a_ready), 64'(tbl[i].e_ar));
      chk($sformatf("v%0d_out_a_valid", i), 64'(bus2.out_a_valid), 64'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_a_source", i), 64'(bus2.out_a_source), 64'(tbl[i].e_osrc));
      chk($sformatf("v%0d_out_a_address", i), 64'(bus2.out_a_address), 64'(tbl[i].e_addr));
      chk($sformatf("v%0d_in_d_valid", i), 64'(bus2.in_d_valid), 64'(tbl[i].e_dv));
      chk($sformatf("v%0d_out_d_ready", i), 64'(bus2.out_d_ready), 64'(tbl[i].e_dr));
      chk($sformatf("v%0d_in_d_source", i), 64'(bus2.in_d_source), 64'(tbl[i].e_dsrc));
      next_cycle();
    end
    drive_d(1'b0, 3'b000, 2'b00);

    // 4-beat PutFull on req0 locks out a pending Get on req1 until beat 4 fires.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive_a(2'b11, 3'd0, 4'd4, 3'd4, 4'd2, 1'b1);
      @(negedge clock);
      chk($sformatf("burst_c%0d_in_a_ready", c), 64'(bus2.in_a_ready),
          (c < 4) ? 64'h1 : 64'h2);
      next_cycle();
    end
    // Single-beat PutFull (size 2) must not lock: grants alternate 0 then 1.
    drive_a(2'b11, 3'd0, 4'd2, 3'd4, 4'd2, 1'b1);
    @(negedge clock);
    chk("putfull_1beat_c0", 64'(bus2.in_a_ready), 64'h1);
    next_cycle();
    @(negedge clock);
    chk("putfull_1beat_c1", 64'(bus2.in_a_ready), 64'h2);
    chk("putfull_1beat_opcode", 64'(bus2.out_a_opcode), 64'd4);
    next_cycle();

    // Req1 alone stalls 3 cycles; req0 joins late but the grant stays frozen on req1.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_a((c < 2) ? 2'b10 : 2'b11, 3'd4, 4'd2, 3'd4, 4'd2, (c == 3));
      @(negedge clock);
      chk($sformatf("stall_c%0d_source", c), 64'(bus2.out_a_source), 64'h5);
      chk($sformatf("stall_c%0d_address", c), 64'(bus2.out_a_address), 64'(A1));
      chk($sformatf("stall_c%0d_in_a_ready", c), 64'(bus2.in_a_ready),
          (c == 3) ? 64'h2 : 64'h0);
      next_cycle();
    end

    // 8-beat PutPartial on req1, reset after beat 2: fresh arbitration picks req0.
    do_reset();
    drive_a(2'b10, 3'd4, 4'd2, 3'd1, 4'd5, 1'b1);
    @(negedge clock);
    chk("rst_burst_beat1", 64'(bus2.in_a_ready), 64'h2);
    next_cycle();
    @(negedge clock);
    chk("rst_burst_beat2", 64'(bus2.in_a_ready), 64'h2);
    next_cycle();
    drive_a(2'b11, 3'd4, 4'd2, 3'd1, 4'd5, 1'b1);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_burst_after_ready", 64'(bus2.in_a_ready), 64'h1);
    chk("rst_burst_after_opcode", 64'(bus2.out_a_opcode), 64'd4);
    next_cycle();
    @(negedge clock);
    chk("rst_burst_new_ready", 64'(bus2.in_a_ready), 64'h2);
    chk("rst_burst_new_size", 64'(bus2.out_a_size), 64'd5);
    next_cycle();
    drive_a(2'b00, 3'd4, 4'd2, 3'd4, 4'd2, 1'b0);

    // N_REQ=3: index 2 routes normally, index 3 is dropped and sets err_sticky.
    bus3.out_d_valid  = 1'b1;
    bus3.out_d_source = {2'd2, 2'b11};
    bus3.in_d_ready   = 3'b100;
    @(negedge clock);
    chk("n3_idx2_in_d_valid", 64'(bus3.in_d_valid), 64'h4);
    chk("n3_idx2_out_d_ready", 64'(bus3.out_d_ready), 64'd1);
    chk("n3_idx2_out_a_valid", 64'(bus3.out_a_valid), 64'd0);
    next_cycle();
    bus3.out_d_source = {2'd3, 2'b01};
    bus3.in_d_ready   = 3'b000;
    @(negedge clock);
    chk("n3_idx3_in_d_valid", 64'(bus3.in_d_valid), 64'h0);
    chk("n3_idx3_out_d_ready", 64'(bus3.out_d_ready), 64'd1);
    chk("n3_err_before_edge", 64'(err3), 64'd0);
    next_cycle();
    bus3.out_d_valid = 1'b0;
    @(negedge clock);
    chk("n3_err_set", 64'(err3), 64'd1);
    next_cycle();
    next_cycle();
    @(negedge clock);
    chk("n3_err_stays", 64'(err3), 64'd1);
    chk("n2_err_clear", 64'(err2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tl_ul_a_arbiter.md
Name: tl_ul_a_arbiter

Overview:
Arbitrates N TileLink-UL requesters onto one shared A channel feeding the downstream Repeater/TLMonitor port. Granting is round-robin, and a requester stays locked for the whole of a multi-beat PutFull/PutPartial burst. Each requester's index is prepended to the outgoing source ID, and D-channel responses are routed back by that index. The block sits between core-side masters and the shared TL-UL slave port.

Parameters:
N_REQ, 2, number of requesters (2..8); IDX_W = max(1, clog2(N_REQ))
SRC_W, 2, requester-side source ID width
ADDR_W, 32, address width
DATA_W, 32, data width; beat = 4 bytes, fixed

Ports:
clock  in  1  clock
reset_n  in  1  async active-low reset
in_a_valid  in  N_REQ  per-requester A valid
in_a_ready  out  N_REQ  per-requester A ready
in_a_opcode  in  3*N_REQ  packed opcodes
in_a_param  in  3*N_REQ  packed params
in_a_size  in  4*N_REQ  packed log2 byte sizes
in_a_source  in  SRC_W*N_REQ  packed source IDs
in_a_address  in  ADDR_W*N_REQ  packed addresses
in_a_mask  in  4*N_REQ  packed byte masks
in_a_data  in  DATA_W*N_REQ  packed data
out_a_valid / out_a_ready  out / in  1  shared A handshake
out_a_opcode, out_a_param, out_a_size, out_a_mask, out_a_address, out_a_data  out  3,3,4,4,ADDR_W,DATA_W  muxed A fields
out_a_source  out  IDX_W+SRC_W  {winner index, source}
out_d_valid / out_d_ready  in / out  1  shared D handshake
out_d_source  in  IDX_W+SRC_W  D source
in_d_valid / in_d_ready  out / in  N_REQ  per-requester D handshake
in_d_source  out  SRC_W  out_d_source[SRC_W-1:0]
err_sticky  out  1  unroutable D beat seen

Behaviour:
- Reset (async, reset_n low): state=IDLE, rr_ptr=0, hold=0, beats_left=0, err_sticky=0. All outputs are then combinationally 0 when no in_a_valid/out_d_valid is asserted.
- Fire = out_a_valid & out_a_ready. in_a_ready[i] = out_a_ready & grant[i]. Grant is one-hot or zero.
- out_a_valid never depends combinationally on out_a_ready. All out_a_* fields are muxed from the granted requester.
- IDLE, hold=0: grant goes to the first valid requester scanning from rr_ptr upward, wrapping at N_REQ.
- IDLE, out_a_valid & !out_a_ready: set hold=1 and latch the grant index. While hold=1 the grant is frozen, which keeps the payload stable per TileLink. hold clears on fire.
- On a first-beat fire: rr_ptr <= (winner+1) mod N_REQ. If opcode is 0 or 1 and size>2: beats_left <= 2^(size-2) - 1, lock <= winner, state <= BURST.
- BURST: only the locked requester is granted. Each fire decrements beats_left. A fire with beats_left==1 returns to IDLE. Other requesters see ready=0. beats_left is 13 bits, enough for size up to 15.
- Single-beat ops (Get, size<=2, atomics/hints) never enter BURST.
- D routing: in_d_valid[i] = out_d_valid & (out_d_source[top IDX_W] == i). out_d_ready = in_d_ready[index]. Routing is per beat and needs no state.
- Index >= N_REQ: out_d_ready=1 (beat dropped) and err_sticky <= 1. err_sticky is cleared only by reset.
- A and D operate independently; simultaneous fires on both channels are legal.
- Reset mid-burst abandons the burst: IDLE, beats_left=0, rr_ptr=0.

Test Plan:
- Both requesters valid with Get size=2, out_a_ready=1 from reset → grants 0,1,0,1 on consecutive cycles; out_a_source = {idx, src}.
- Req0 PutFull size=4 (4 beats), req1 Get pending → req0 holds 4 consecutive fires, in_a_ready[1]=0 throughout, req1 granted on cycle 5.
- Req1 alone valid with out_a_ready=0 for 3 cycles, then req0 raises valid → grant stays on req1, payload stable, req1 fires when ready=1.
- out_d_source=3'b1_01 with in_d_ready[1]=1 → in_d_valid=2'b10, in_d_source=01, out_d_ready=1.
- N_REQ=3, out_d_source index=3 → out_d_ready=1, no in_d_valid asserted, err_sticky=1 next cycle, stays 1.
- reset_n low after beat 2 of an 8-beat PutPartial → state=IDLE, rr_ptr=0, out_a_valid follows fresh arbitration after release.
